nes_receiver: RTL and testbench
===============================

Name: nes_receiver

Overview:
- Serial NES controller reader that sits directly upstream of the game's input controller.
- Generates the NES latch and clock waveforms on the uio pins and samples the controller's serial data line.
- Publishes an 8-bit active-high button vector with a one-cycle valid strobe.
- Started once per frame by a pulse on start, driven from frame_end in the top level.

Parameters:
- HALF_PERIOD, 151: clk cycles per protocol tick. 151 ≈ 6 us at 25.175 MHz. Must be ≥2.
- TICK_W, $clog2(HALF_PERIOD): tick counter width. Derived; do not override.

Ports:
- clk  in  1  system clock (pixel clock)
- rst_n  in  1  synchronous, active-low reset
- start  in  1  single-cycle poll request
- nes_data  in  1  controller serial data; asynchronous, active-low (0 = pressed)
- nes_latch  out  1  latch pulse to controller
- nes_clk  out  1  shift clock to controller
- buttons  out  8  active-high, registered. Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right
- valid  out  1  one-cycle pulse when buttons is updated
- busy  out  1  high while a poll is in progress

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; nes_latch=0, nes_clk=0, buttons=8'h00, valid=0, busy=0.
  - Tick counter, bit index and shift register cleared; synchronizer flops set to 1.
  - Reset mid-poll aborts immediately. No valid is issued; buttons are cleared.
- Synchronizer: nes_data passes through 2 flops (sync_2ff). All sampling uses the synchronized value.
- Tick counter:
  - Counts 0..HALF_PERIOD-1 while busy; tick_end when count==HALF_PERIOD-1.
  - Resets to 0 on each state change.
- State machine (all outputs registered):
  - IDLE: latch=0, clk=0, busy=0. start=1 → LATCH. Also clears bit index and sets busy=1.
  - LATCH: latch=1 for 2 ticks (2*HALF_PERIOD cycles). Then → READ_LOW with latch=0.
  - READ_LOW: clk=0 for 1 tick. On tick_end, shift_reg[bit_idx] ← ~synced_data, then → READ_HIGH.
  - READ_HIGH: clk=1 for 1 tick. On tick_end: if bit_idx==7 → DONE; else bit_idx+1 and → READ_LOW.
  - DONE (1 cycle): buttons ← shift_reg, valid=1, clk=0, busy=0. Then → IDLE.
- Timing:
  - 8 clock pulses per poll. The 8th pulse follows the last sample (protocol-compliant, data ignored).
  - Latency from start accepted to valid = 18*HALF_PERIOD + 1 cycles.
  - buttons holds its value between polls.
- Boundary conditions:
  - start while busy: ignored, no queueing.
  - start in the same cycle as DONE: ignored.
  - start on the first IDLE cycle after DONE: accepted.
  - Controller absent (data pulled high): buttons=8'h00.
  - nes_data changing mid-tick: only the synchronized value at the READ_LOW tick_end matters.
- Latch and clock are never high simultaneously.

Decomposition:
- Shared package nes_pkg:
  - State encoding: IDLE, LATCH, READ_LOW, READ_HIGH, DONE (3 bits).
  - Button index constants BTN_A..BTN_RIGHT (0..7).
  - LATCH_TICKS=2, NUM_BITS=8.
  - The top-level button-to-action mapping uses the same package.
- One sub-module: sync_2ff (2-flop synchronizer, reset value parameterised, here 1).
- The FSM, counters and shift register stay in nes_receiver.

Test Plan (HALF_PERIOD=4 in bench; bench controller model drives bit 0 on latch fall and shifts on each nes_clk rising edge, active-low):
- Reset: rst_n=0 for 3 cycles → nes_latch=0, nes_clk=0, buttons=8'h00, valid=0, busy=0.
- Waveform check: start pulse → nes_latch high for exactly 8 cycles, then 8 nes_clk pulses each 4 low/4 high. valid occurs exactly 73 cycles after start was sampled.
- Pattern: model presses A and Right (serial 0,1,1,1,1,1,1,0) → buttons=8'h81 with a single valid pulse. Next poll with nothing pressed → buttons=8'h00.
- Alternating buttons: B, Start, Down, Right pressed → buttons=8'hAA; then A, Select, Up, Left → 8'h55.
- Busy rejection: start re-asserted at cycles 5 and 40 of a poll → no extra latch pulse, one valid only. start in the DONE cycle ignored; start one cycle later accepted.
- Reset mid-poll: rst_n low during READ_HIGH of bit 3 → outputs return to reset values next cycle, no valid. The next start produces a complete, correct poll.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller reader: FSM encoding, button
// indices and protocol constants, also used by the top-level action mapping.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LATCH     = 3'd1,
    READ_LOW  = 3'd2,
    READ_HIGH = 3'd3,
    DONE      = 3'd4
  } nes_state_e;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam int LATCH_TICKS = 2;
  localparam int NUM_BITS    = 8;

  typedef logic [NUM_BITS-1:0] btn_vec_t;

endpackage

// File: rtl/nes_receiver_if.sv
// Poll request, controller pins and button result of the NES reader.
// slave is the reader's view; master is the frame logic / controller side.
interface nes_receiver_if;
  import nes_pkg::*;

  logic     start;
  logic     nes_data;
  logic     nes_latch;
  logic     nes_clk;
  btn_vec_t buttons;
  logic     valid;
  logic     busy;

  modport slave (
    input  start, nes_data,
    output nes_latch, nes_clk, buttons, valid, busy
  );

  modport master (
    output start, nes_data,
    input  nes_latch, nes_clk, buttons, valid, busy
  );

endinterface

// File: rtl/nes_receiver_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input; 2-cycle latency,
// reset value selectable so an idle-high line reads as inactive out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/nes_receiver.sv
// NES controller poller: latch, 8 clocked reads, then a registered button
// vector with a one-cycle valid; start is ignored unless idle (no queueing).
module nes_receiver
  import nes_pkg::*;
#(
  parameter  int HALF_PERIOD = 151,
  localparam int TICK_W      = $clog2(HALF_PERIOD)
) (
  input  logic           clk,
  input  logic           rst_n,
  nes_receiver_if.slave  bus
);

  localparam int LT_W = (LATCH_TICKS > 1) ? $clog2(LATCH_TICKS) : 1;
  localparam int BI_W = $clog2(NUM_BITS);

  nes_state_e       state_q, state_d;
  logic [TICK_W-1:0] tick_q;
  logic [LT_W-1:0]   ltick_q;
  logic [BI_W-1:0]   bit_idx_q;
  btn_vec_t          shift_q;

  logic     latch_q, latch_d;
  logic     nclk_q, nclk_d;
  logic     busy_q, busy_d;
  logic     valid_q, valid_d;
  btn_vec_t buttons_q, buttons_d;

  logic data_sync;
  logic tick_end;
  logic active;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.nes_data),
    .q_o   (data_sync)
  );

  assign tick_end = (tick_q == TICK_W'(HALF_PERIOD - 1));
  assign active   = (state_q == LATCH) || (state_q == READ_LOW) || (state_q == READ_HIGH);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (bus.start) state_d = LATCH;
      LATCH:     if (tick_end && ltick_q == LT_W'(LATCH_TICKS - 1)) state_d = READ_LOW;
      READ_LOW:  if (tick_end) state_d = READ_HIGH;
      READ_HIGH: if (tick_end) state_d = (bit_idx_q == BI_W'(NUM_BITS - 1)) ? DONE : READ_LOW;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the current state and registered, so every pin
  // lags the state by one cycle; this is what makes start->valid 18*HP+1.
  always_comb begin
    latch_d   = (state_q == LATCH);
    nclk_d    = (state_q == READ_HIGH);
    busy_d    = active;
    valid_d   = (state_q == DONE);
    buttons_d = (state_q == DONE) ? shift_q : buttons_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      buttons_q <= '0;
    end else begin
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      buttons_q <= buttons_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_q    <= '0;
      ltick_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      if (state_d != state_q || !active) tick_q <= '0;
      else if (tick_end)                 tick_q <= '0;
      else                               tick_q <= tick_q + TICK_W'(1);

      if (state_q != LATCH)  ltick_q <= '0;
      else if (tick_end)     ltick_q <= ltick_q + LT_W'(1);

      if (state_q == IDLE && bus.start) begin
        bit_idx_q <= '0;
        shift_q   <= '0;
      end else if (state_q == READ_HIGH && tick_end && bit_idx_q != BI_W'(NUM_BITS - 1)) begin
        bit_idx_q <= bit_idx_q + BI_W'(1);
      end

      // Controller data is active-low; store as pressed=1.
      if (state_q == READ_LOW && tick_end) shift_q[bit_idx_q] <= ~data_sync;
    end
  end

  assign bus.nes_latch = latch_q;
  assign bus.nes_clk   = nclk_q;
  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.buttons   = buttons_q;

endmodule

// File: tb/tb_nes_receiver.sv
// Directed bench for nes_receiver with HALF_PERIOD=4 and a behavioural
// controller that presents bit 0 on latch fall and shifts on nes_clk rise.
module tb_nes_receiver;

  logic clk;
  logic rst_n;
  logic [7:0] press;
  int   n_pass;
  int   n_chk;
  int   bidx;

  nes_receiver_if bus ();

  nes_receiver #(.HALF_PERIOD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: active-low serial data, reloaded on latch fall.
  initial begin
    bidx = 8;
    bus.nes_data = 1'b1;
  end
  always @(negedge bus.nes_latch or posedge bus.nes_clk) begin
    if (bus.nes_clk === 1'b1) bidx = bidx + 1;
    else                      bidx = 0;
    bus.nes_data = (bidx < 8) ? ~press[bidx[2:0]] : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One poll with full waveform monitoring; rej re-asserts start mid-poll.
  task automatic poll(input logic [7:0] pat, input logic [7:0] exp, input bit rej, input string tag);
    int lat = 0, rises = 0, pul = 0, ovl = 0, vat = -1, vcnt = 0;
    int hi_run = 0, lo_run = 0, hi_ok = 1, lo_ok = 1;
    logic prev_clk = 1'b0, prev_lat = 1'b0;
    press = pat;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      if (bus.nes_latch) lat++;
      if (bus.nes_latch && !prev_lat) rises++;
      if (bus.nes_latch && bus.nes_clk) ovl++;
      if (bus.nes_clk) hi_run++;
      else if (prev_clk) begin
        if (hi_run != 4) hi_ok = 0;
        hi_run = 0;
      end
      if (!bus.nes_latch && lat > 0 && !bus.nes_clk) lo_run++;
      if (bus.nes_clk && !prev_clk) begin
        pul++;
        if (lo_run != 4) lo_ok = 0;
        lo_run = 0;
      end
      if (bus.valid) begin
        vcnt++;
        if (vat < 0) vat = k;
      end
      prev_clk = bus.nes_clk;
      prev_lat = bus.nes_latch;
      bus.start = rej && (k == 5 || k == 40);
    end
    bus.start = 1'b0;
    chk({tag, " latch_cycles"}, lat, 8);
    chk({tag, " latch_pulses"}, rises, 1);
    chk({tag, " clk_pulses"}, pul, 8);
    chk({tag, " clk_high_4"}, hi_ok, 1);
    chk({tag, " clk_low_4"}, lo_ok, 1);
    chk({tag, " overlap"}, ovl, 0);
    chk({tag, " valid_latency"}, vat, 73);
    chk({tag, " valid_count"}, vcnt, 1);
    chk({tag, " buttons"}, bus.buttons, exp);
    chk({tag, " busy_idle"}, bus.busy, 0);
  endtask

  initial begin
    int vat;
    n_pass = 0;
    n_chk = 0;
    press = 8'h00;
    bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst latch", bus.nes_latch, 0);
    chk("rst clk", bus.nes_clk, 0);
    chk("rst buttons", bus.buttons, 8'h00);
    chk("rst valid", bus.valid, 0);
    chk("rst busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    poll(8'h81, 8'h81, 1'b0, "a_right");
    poll(8'h00, 8'h00, 1'b0, "none");
    poll(8'hAA, 8'hAA, 1'b0, "alt_aa");
    poll(8'h55, 8'h55, 1'b1, "alt_55_rej");

    // start during DONE is ignored, start on the following idle cycle wins.
    press = 8'h3C;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 73; k++) begin
      @(negedge clk);
      bus.start = (k == 72);
    end
    chk("done valid", bus.valid, 1);
    chk("done buttons", bus.buttons, 8'h3C);
    press = 8'h12;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_start ignored", bus.nes_latch, 0);
    @(negedge clk);
    chk("next_start latch", bus.nes_latch, 1);
    vat = -1;
    for (int k = 2; k <= 90; k++) begin
      @(negedge clk);
      if (bus.valid && vat < 0) vat = k;
    end
    chk("next_start latency", vat, 73);
    chk("next_start buttons", bus.buttons, 8'h12);

    // Reset during READ_HIGH of bit 3.
    press = 8'hF0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 37; k++) @(negedge clk);
    chk("mid pre clk_high", bus.nes_clk, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid latch", bus.nes_latch, 0);
    chk("mid clk", bus.nes_clk, 0);
    chk("mid buttons", bus.buttons, 8'h00);
    chk("mid valid", bus.valid, 0);
    chk("mid busy", bus.busy, 0);
    vat = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus.valid) vat++;
    end
    chk("mid no_valid", vat, 0);
    poll(8'hC3, 8'hC3, 1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
